// File: rtl/issue_ctrl.sv
// issue_ctrl: dual-issue scheduler between the issue buffer and two execution lanes.
// Decides per cycle how many of the two head entries (A older, B younger) issue,
// tracks in-flight multi-cycle destinations in a per-register busy scoreboard,
// and counts dual-issue cycles.
module issue_ctrl #(
  parameter int LAT_LD  = 2,
  parameter int LAT_MUL = 2,
  parameter int CW      = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  i_is_valid,
  input  logic [4:0]  a_rd,
  input  logic        a_we,
  input  logic [4:0]  a_rs1,
  input  logic [4:0]  a_rs2,
  input  logic        a_use1,
  input  logic        a_use2,
  input  logic [1:0]  a_class,
  input  logic [4:0]  b_rd,
  input  logic        b_we,
  input  logic [4:0]  b_rs1,
  input  logic [4:0]  b_rs2,
  input  logic        b_use1,
  input  logic        b_use2,
  input  logic [1:0]  b_class,
  input  logic        flush_BR,
  input  logic        stall_DCache,
  output logic [1:0]  o_usingNUM,
  output logic        o_hazard,
  output logic [31:0] o_dual_cnt
);

  localparam logic [1:0] CL_ALU = 2'd0;
  localparam logic [1:0] CL_MEM = 2'd2;
  localparam logic [1:0] CL_MUL = 2'd3;

  localparam logic [CW-1:0] LD_V  = CW'(LAT_LD);
  localparam logic [CW-1:0] MUL_V = CW'(LAT_MUL);

  logic [CW-1:0] cnt [32];
  logic [31:0]   busy_vec;
  logic          a_blk;
  logic          b_blk;
  logic [1:0]    num;
  logic          a_iss;
  logic          b_iss;
  logic          set_a;
  logic          set_b;
  logic [CW-1:0] a_lat;
  logic [CW-1:0] b_lat;

  // Busy flags from the scoreboard; r0 is hardwired to never busy.
  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < 32; r++) begin
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  // Blocking conditions for both slots and the resulting issue count.
  always_comb begin
    a_blk = (a_use1 && busy_vec[a_rs1]) || (a_use2 && busy_vec[a_rs2]) ||
            (a_we && busy_vec[a_rd]);
    b_blk = (b_use1 && busy_vec[b_rs1]) || (b_use2 && busy_vec[b_rs2]) ||
            (b_we && busy_vec[b_rd]) ||
            (a_we && (a_rd != 5'd0) &&
             ((b_use1 && (b_rs1 == a_rd)) || (b_use2 && (b_rs2 == a_rd)))) ||
            (a_we && b_we && (a_rd == b_rd) && (a_rd != 5'd0)) ||
            ((a_class == b_class) && (a_class != CL_ALU));
    num = 2'd0;
    if (!rstn || flush_BR || stall_DCache || !i_is_valid[1] || a_blk) begin
      num = 2'd0;
    end else if (!i_is_valid[0] || b_blk) begin
      num = 2'd1;
    end else begin
      num = 2'd2;
    end
  end

  assign o_usingNUM = num;

  // Scoreboard set requests from issued multi-cycle producers.
  always_comb begin
    a_iss = (num != 2'd0);
    b_iss = (num == 2'd2);
    set_a = a_iss && a_we && (a_rd != 5'd0) && ((a_class == CL_MEM) || (a_class == CL_MUL));
    set_b = b_iss && b_we && (b_rd != 5'd0) && ((b_class == CL_MEM) || (b_class == CL_MUL));
    a_lat = (a_class == CL_MEM) ? LD_V : MUL_V;
    b_lat = (b_class == CL_MEM) ? LD_V : MUL_V;
  end

  // Scoreboard counters: flush clears, stall freezes, set beats decrement.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else if (flush_BR) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else if (!stall_DCache) begin
      for (int r = 1; r < 32; r++) begin
        if (set_a && (a_rd == 5'(r))) begin
          cnt[r] <= a_lat;
        end else if (set_b && (b_rd == 5'(r))) begin
          cnt[r] <= b_lat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CW'(1);
        end
      end
    end
  end

  // Hazard flag and dual-issue counter, registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_hazard   <= 1'b0;
      o_dual_cnt <= '0;
    end else begin
      o_hazard <= i_is_valid[1] && !flush_BR && !stall_DCache && a_blk;
      if (num == 2'd2) o_dual_cnt <= o_dual_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: scoreboard bench for issue_ctrl. A timestamp-based reference
// model predicts each cycle's outputs; a monitor pops and compares them.
module tb_issue_ctrl;

  localparam int LAT_LD  = 2;
  localparam int LAT_MUL = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  vld;
  logic [4:0]  a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
  logic        a_we, a_use1, a_use2, b_we, b_use1, b_use2;
  logic [1:0]  a_class, b_class;
  logic        flush, stall;
  logic [1:0]  o_num;
  logic        o_hz;
  logic [31:0] o_dual;

  always #5 clk = ~clk;

  issue_ctrl #(.LAT_LD(LAT_LD), .LAT_MUL(LAT_MUL), .CW(2)) dut (
    .clk(clk), .rstn(rstn), .i_is_valid(vld),
    .a_rd(a_rd), .a_we(a_we), .a_rs1(a_rs1), .a_rs2(a_rs2),
    .a_use1(a_use1), .a_use2(a_use2), .a_class(a_class),
    .b_rd(b_rd), .b_we(b_we), .b_rs1(b_rs1), .b_rs2(b_rs2),
    .b_use1(b_use1), .b_use2(b_use2), .b_class(b_class),
    .flush_BR(flush), .stall_DCache(stall),
    .o_usingNUM(o_num), .o_hazard(o_hz), .o_dual_cnt(o_dual)
  );

  typedef struct {
    logic [1:0]  num;
    logic        hz;
    logic [31:0] dual;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: t counts cycles that neither stall nor flush; a register
  // is busy while t is below the time its producer result becomes usable.
  longint      t = 0;
  longint      ready_at [32];
  logic        m_hz = 1'b0;
  logic [31:0] m_dual = '0;

  function automatic bit m_busy(input logic [4:0] r);
    return (r != 5'd0) && (t < ready_at[r]);
  endfunction

  function automatic bit m_ablk();
    return (a_use1 && m_busy(a_rs1)) || (a_use2 && m_busy(a_rs2)) || (a_we && m_busy(a_rd));
  endfunction

  function automatic bit m_bblk();
    bit raw, waw, str;
    raw = a_we && a_rd != 0 && ((b_use1 && b_rs1 == a_rd) || (b_use2 && b_rs2 == a_rd));
    waw = a_we && b_we && a_rd == b_rd && a_rd != 0;
    str = (a_class == b_class) && (a_class != 2'd0);
    return (b_use1 && m_busy(b_rs1)) || (b_use2 && m_busy(b_rs2)) || (b_we && m_busy(b_rd)) ||
           raw || waw || str;
  endfunction

  function automatic longint lat_of(input logic [1:0] c);
    return (c == 2'd2) ? longint'(LAT_LD) : longint'(LAT_MUL);
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
  endtask

  // Predict this cycle, queue the expectation, then advance one clock.
  task automatic step();
    exp_t e;
    bit ab, bb;
    int n;
    e.cyc = cyc;
    if (!rstn) begin
      clear_model();
      m_hz = 1'b0;
      m_dual = '0;
      e.num = 2'd0; e.hz = 1'b0; e.dual = '0;
      q.push_back(e);
    end else begin
      ab = m_ablk();
      bb = m_bblk();
      if (flush || stall || !vld[1] || ab) n = 0;
      else if (!vld[0] || bb) n = 1;
      else n = 2;
      e.num = 2'(n); e.hz = m_hz; e.dual = m_dual;
      q.push_back(e);
      m_hz = vld[1] && !flush && !stall && ab;
      if (n == 2) m_dual = m_dual + 1;
      if (flush) begin
        clear_model();
      end else if (!stall) begin
        if (n >= 1 && a_we && a_rd != 0 && a_class[1]) ready_at[a_rd] = t + 1 + lat_of(a_class);
        if (n == 2 && b_we && b_rd != 0 && b_class[1]) ready_at[b_rd] = t + 1 + lat_of(b_class);
        t++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sa(input logic v, input logic [1:0] c, input logic we, input logic [4:0] rd,
                    input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2);
    vld[1] = v; a_class = c; a_we = we; a_rd = rd;
    a_rs1 = s1; a_use1 = u1; a_rs2 = s2; a_use2 = u2;
  endtask

  task automatic sb(input logic v, input logic [1:0] c, input logic we, input logic [4:0] rd,
                    input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2);
    vld[0] = v; b_class = c; b_we = we; b_rd = rd;
    b_rs1 = s1; b_use1 = u1; b_rs2 = s2; b_use2 = u2;
  endtask

  task automatic rand_inputs();
    sa($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 7)),
       5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
    sb(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 7)),
       5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
    flush = ($urandom_range(0, 29) == 0);
    stall = ($urandom_range(0, 9) == 0);
  endtask

  // Monitor: every cycle the DUT presents a result; compare it with the queue head.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (o_num !== e.num) begin
        errors++;
        $display("FAIL usingNUM cyc=%0d got=%0d want=%0d", e.cyc, o_num, e.num);
      end
      checks++;
      if (o_hz !== e.hz) begin
        errors++;
        $display("FAIL hazard cyc=%0d got=%0b want=%0b", e.cyc, o_hz, e.hz);
      end
      checks++;
      if (o_dual !== e.dual) begin
        errors++;
        $display("FAIL dual_cnt cyc=%0d got=%0d want=%0d", e.cyc, o_dual, e.dual);
      end
    end
  end

  initial begin
    rstn = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    clear_model();
    sa(1, 0, 0, 0, 0, 0, 0, 0);
    sb(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    // reset state
    step();
    step();
    rstn = 1'b1;
    // independent ALU pair
    sa(1, 0, 1, 1, 0, 0, 0, 0); sb(1, 0, 1, 3, 2, 1, 0, 0); step();
    sa(0, 0, 0, 0, 0, 0, 0, 0); sb(0, 0, 0, 0, 0, 0, 0, 0); step();
    // intra-pair RAW, then B moves to head with an independent follower
    sa(1, 0, 1, 5, 0, 0, 0, 0); sb(1, 0, 1, 6, 5, 1, 0, 0); step();
    sa(1, 0, 1, 6, 5, 1, 0, 0); sb(1, 0, 1, 8, 2, 1, 0, 0); step();
    // load-use on r7
    sa(1, 2, 1, 7, 1, 1, 0, 0); sb(0, 0, 0, 0, 0, 0, 0, 0); step();
    sa(1, 0, 1, 4, 0, 0, 7, 1); step(); step(); step(); step();
    // stall freeze with a load in flight
    sa(1, 2, 1, 7, 1, 1, 0, 0); step();
    stall = 1'b1; sa(1, 0, 1, 4, 7, 1, 0, 0); step(); step(); step();
    stall = 1'b0; step(); step(); step(); step();
    // structural pairs and r0 destination
    sa(1, 2, 0, 0, 1, 1, 0, 0); sb(1, 2, 0, 0, 2, 1, 0, 0); step();
    sa(1, 3, 1, 10, 1, 1, 0, 0); sb(1, 0, 1, 11, 2, 1, 0, 0); step();
    sa(1, 1, 0, 0, 1, 1, 2, 1); sb(1, 1, 0, 0, 3, 1, 0, 0); step();
    sa(1, 2, 1, 0, 1, 1, 0, 0); sb(0, 0, 0, 0, 0, 0, 0, 0); step();
    sa(1, 0, 1, 12, 0, 1, 0, 1); sb(1, 0, 1, 13, 0, 1, 0, 0); step();
    // MULDIV latency and B-slot multi-cycle producer
    sa(1, 0, 1, 14, 0, 0, 0, 0); sb(1, 3, 1, 15, 0, 0, 0, 0); step();
    sa(1, 0, 1, 16, 15, 1, 0, 0); sb(0, 0, 0, 0, 0, 0, 0, 0); step(); step(); step(); step();
    // flush squashes an in-flight load
    sa(1, 2, 1, 9, 0, 0, 0, 0); step();
    flush = 1'b1; sa(1, 0, 1, 17, 9, 1, 0, 0); sb(1, 0, 1, 18, 0, 0, 0, 0); step();
    flush = 1'b0; step();
    // flush and stall together
    sa(1, 2, 1, 9, 0, 0, 0, 0); sb(0, 0, 0, 0, 0, 0, 0, 0); step();
    flush = 1'b1; stall = 1'b1; sa(1, 0, 1, 17, 9, 1, 0, 0); step();
    flush = 1'b0; stall = 1'b0; step();
    // mid-operation asynchronous reset
    sa(1, 3, 1, 20, 0, 0, 0, 0); step();
    rstn = 1'b0; step();
    rstn = 1'b1; sa(1, 0, 1, 21, 20, 1, 0, 0); step();
    // randomized traffic with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      rstn = ($urandom_range(0, 499) != 0);
      step();
    end
    rstn = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
